// File: rtl/fnd_sched_pkg.sv
// Shared types, mode codes and index helpers for the FND display-source scheduler.
package fnd_sched_pkg;

   localparam int NUM_SRC = 5;

   typedef enum logic [1:0] {
      S_MANUAL,
      S_AUTO,
      S_PEEK
   } state_t;

   localparam logic [2:0] MODE_MSEC_SEC = 3'b000;
   localparam logic [2:0] MODE_MIN_HOUR = 3'b001;
   localparam logic [2:0] MODE_DIST     = 3'b010;
   localparam logic [2:0] MODE_TEMP     = 3'b100;
   localparam logic [2:0] MODE_HUMI     = 3'b101;

   // Source index to the select code the FND controller expects.
   function automatic logic [2:0] idx_to_mode(input logic [2:0] idx);
      logic [2:0] mode;
      case (idx)
         3'd0:    mode = MODE_MSEC_SEC;
         3'd1:    mode = MODE_MIN_HOUR;
         3'd2:    mode = MODE_DIST;
         3'd3:    mode = MODE_TEMP;
         3'd4:    mode = MODE_HUMI;
         default: mode = MODE_MSEC_SEC;
      endcase
      return mode;
   endfunction

   // First valid index after idx in circular order; idx itself if nothing else is valid.
   // Walks the offsets from farthest to nearest so the nearest valid one is what remains.
   function automatic logic [2:0] next_valid(input logic [2:0] idx,
                                             input logic [NUM_SRC-1:0] valid);
      logic [2:0] result;
      int cand;
      result = idx;
      for (int step = NUM_SRC - 1; step >= 1; step--) begin
         cand = (int'(idx) + step) % NUM_SRC;
         if (valid[cand]) begin
            result = 3'(cand);
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fnd_mode_scheduler_tick_gen.sv
// Prescaler turning the system clock into a one-cycle 1 ms tick pulse.
module fnd_tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Free-running count 0..TICK_DIV-1, wrapping to zero.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   // Prescaler register, cleared by the active-low asynchronous reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fnd_mode_scheduler.sv
// FND display-source scheduler: manual stepping, timed auto-rotation and skipping of
// invalid sensors. Optional peek of freshly updated sensors with macro FND_SCHED_PEEK_EN.
module fnd_mode_scheduler
   import fnd_sched_pkg::*;
#(
   parameter int TICK_DIV    = 100000,
   parameter int DWELL_TICKS = 2000,
   parameter int PEEK_TICKS  = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn_next,
   input  logic                auto_en,
   input  logic [NUM_SRC-1:0]  src_valid,
   input  logic [NUM_SRC-1:0]  upd_pulse,
   output logic [2:0]          sw_mode,
   output logic [2:0]          cur_idx,
   output logic                auto_active,
   output logic                peek_active
);

   localparam int DWL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [DWL_W-1:0] DWELL_LAST = DWL_W'(DWELL_TICKS - 1);

   logic               tick;
   logic [NUM_SRC-1:0] eff_valid;
   state_t             want_state;

   state_t             state_q, state_d;
   logic [2:0]         cur_idx_q, cur_idx_d;
   logic [2:0]         sw_mode_q, sw_mode_d;
   logic [DWL_W-1:0]   dwell_q, dwell_d;

   fnd_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // The two clock sources never go invalid; the auto_en level picks manual vs auto.
   assign eff_valid  = src_valid | 5'b00011;
   assign want_state = auto_en ? S_AUTO : S_MANUAL;

`ifdef FND_SCHED_PEEK_EN
   localparam int PK_W = (PEEK_TICKS > 1) ? $clog2(PEEK_TICKS) : 1;
   localparam logic [PK_W-1:0] PEEK_LAST = PK_W'(PEEK_TICKS - 1);

   logic [2:0]      saved_idx_q, saved_idx_d;
   logic [PK_W-1:0] peek_q, peek_d;
   logic            peek_hit;
   logic [2:0]      peek_idx;

   // Lowest-numbered freshly updated, valid source other than the one on screen.
   always_comb begin
      peek_hit = 1'b0;
      peek_idx = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (upd_pulse[k] && eff_valid[k] && (3'(k) != cur_idx_q)) begin
            peek_hit = 1'b1;
            peek_idx = 3'(k);
         end
      end
   end
`else
   logic unused_upd;
   localparam int unused_peek_ticks = PEEK_TICKS;
   assign unused_upd = ^upd_pulse;
`endif

   // Next state, index and counters; validity loss beats btn_next beats dwell expiry.
   always_comb begin
      state_d   = state_q;
      cur_idx_d = cur_idx_q;
      dwell_d   = dwell_q;
`ifdef FND_SCHED_PEEK_EN
      saved_idx_d = saved_idx_q;
      peek_d      = peek_q;
`endif
      case (state_q)
         S_MANUAL, S_AUTO: begin
            state_d = want_state;
            if (!eff_valid[cur_idx_q] || btn_next) begin
               cur_idx_d = next_valid(cur_idx_q, eff_valid);
               dwell_d   = '0;
            end
`ifdef FND_SCHED_PEEK_EN
            else if (peek_hit) begin
               saved_idx_d = cur_idx_q;
               cur_idx_d   = peek_idx;
               peek_d      = '0;
               state_d     = S_PEEK;
            end
`endif
            else if ((state_q == S_AUTO) && tick) begin
               if (dwell_q == DWELL_LAST) begin
                  cur_idx_d = next_valid(cur_idx_q, eff_valid);
                  dwell_d   = '0;
               end else begin
                  dwell_d = dwell_q + DWL_W'(1);
               end
            end
         end
`ifdef FND_SCHED_PEEK_EN
         // The saved mode always follows auto_en, so returning uses the live level.
         S_PEEK: begin
            if (!eff_valid[cur_idx_q]) begin
               state_d   = want_state;
               cur_idx_d = saved_idx_q;
            end else if (btn_next) begin
               state_d   = want_state;
               cur_idx_d = next_valid(saved_idx_q, eff_valid);
            end else if (tick) begin
               if (peek_q == PEEK_LAST) begin
                  state_d   = want_state;
                  cur_idx_d = saved_idx_q;
               end else begin
                  peek_d = peek_q + PK_W'(1);
               end
            end
         end
`endif
         default: begin
            state_d = S_MANUAL;
         end
      endcase
      if ((state_q != S_AUTO) || (state_d != S_AUTO)) begin
         dwell_d = '0;
      end
      sw_mode_d = idx_to_mode(cur_idx_d);
   end

   // Scheduler state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_MANUAL;
         cur_idx_q <= '0;
         sw_mode_q <= MODE_MSEC_SEC;
         dwell_q   <= '0;
      end else begin
         state_q   <= state_d;
         cur_idx_q <= cur_idx_d;
         sw_mode_q <= sw_mode_d;
         dwell_q   <= dwell_d;
      end
   end

`ifdef FND_SCHED_PEEK_EN
   // Peek bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         saved_idx_q <= '0;
         peek_q      <= '0;
      end else begin
         saved_idx_q <= saved_idx_d;
         peek_q      <= peek_d;
      end
   end

   assign peek_active = (state_q == S_PEEK);
`else
   assign peek_active = 1'b0;
`endif

   assign sw_mode     = sw_mode_q;
   assign cur_idx     = cur_idx_q;
   assign auto_active = (state_q == S_AUTO);

endmodule
